// File: rtl/mc_core_hs.sv
// Multicycle MIPS-subset core with a single unified memory port that waits on mem_ready.
// Datapath registers, the register file and the control FSM all live in this module.
module mc_core_hs #(
  parameter int               WIDTH    = 32,
  parameter int               NREG     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [3:0]       state,
  output logic             halted
);
  // Handshake: an access is offered while mem_req=1 and completes on the rising edge
  // where mem_ready=1; mem_addr/mem_we/mem_wdata hold steady until then, and
  // mem_ready is don't-care whenever mem_req=0.
  localparam int RW = $clog2(NREG);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_ADDIWB = 4'd10,
    ST_JUMP   = 4'd11,
    ST_HALT   = 4'd12
  } state_t;

  state_t           st;
  logic [31:0]      ir;
  logic [WIDTH-1:0] a, b, aluout, mdr;
  logic [WIDTH-1:0] rf [NREG];

  logic [5:0]       opcode, funct;
  logic [RW-1:0]    rs_i, rt_i, rd_i;
  logic [WIDTH-1:0] imm_sx, rf_a, rf_b, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ok;
  logic             rf_we;
  logic [RW-1:0]    rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic             br_taken;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  // Only the low log2(NREG) bits of each register field select a register.
  assign rs_i   = ir[21 +: RW];
  assign rt_i   = ir[16 +: RW];
  assign rd_i   = ir[11 +: RW];
  assign imm_sx = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign rf_a   = (rs_i == '0) ? '0 : rf[rs_i];
  assign rf_b   = (rt_i == '0) ? '0 : rf[rt_i];
  assign diff   = a - b;
  assign br_taken = (opcode == OP_BEQ) ? (diff == '0) : (diff != '0);

  assign state     = st;
  assign mem_addr  = (st == ST_FETCH) ? pc : aluout;
  assign mem_wdata = b;

  always_comb begin
    alu_ok  = 1'b1;
    alu_res = '0;
    case (funct)
      FN_ADD:  alu_res = a + b;
      FN_SUB:  alu_res = a - b;
      FN_AND:  alu_res = a & b;
      FN_OR:   alu_res = a | b;
      FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_ok  = 1'b0;
    endcase
  end

  assign rf_we = (st == ST_ALUWB) || (st == ST_MEMWB) || (st == ST_ADDIWB);
  assign rf_wa = (st == ST_ALUWB) ? rd_i : rt_i;
  assign rf_wd = (st == ST_MEMWB) ? mdr : aluout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (rf_we && (rf_wa != '0)) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= ST_RST;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      aluout  <= '0;
      mdr     <= '0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (st)
        ST_RST: begin
          st      <= ST_FETCH;
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
        end
        ST_FETCH: if (mem_ready) begin
          ir      <= mem_rdata[31:0];
          pc      <= pc + WIDTH'(4);
          st      <= ST_DECODE;
          mem_req <= 1'b0;
        end
        ST_DECODE: begin
          a      <= rf_a;
          b      <= rf_b;
          aluout <= pc + (imm_sx << 2);
          case (opcode)
            OP_R:                    st <= ST_EXEC;
            OP_LW, OP_SW, OP_ADDI:   st <= ST_MEMADR;
            OP_BEQ, OP_BNE:          st <= ST_BRANCH;
            OP_J:                    st <= ST_JUMP;
            default: begin
              st     <= ST_HALT;
              halted <= 1'b1;
            end
          endcase
        end
        ST_MEMADR: begin
          aluout <= a + imm_sx;
          case (opcode)
            OP_LW: begin
              st      <= ST_MEMRD;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
            OP_SW: begin
              st      <= ST_MEMWR;
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
            end
            default: st <= ST_ADDIWB;
          endcase
        end
        ST_MEMRD: if (mem_ready) begin
          mdr     <= mem_rdata;
          st      <= ST_MEMWB;
          mem_req <= 1'b0;
        end
        ST_MEMWR: if (mem_ready) begin
          // Store completes straight into the next fetch, so mem_req stays high.
          st      <= ST_FETCH;
          mem_we  <= 1'b0;
        end
        ST_EXEC: begin
          if (alu_ok) begin
            aluout <= alu_res;
            st     <= ST_ALUWB;
          end else begin
            st     <= ST_HALT;
            halted <= 1'b1;
          end
        end
        ST_BRANCH: begin
          if (br_taken) pc <= aluout;
          st      <= ST_FETCH;
          mem_req <= 1'b1;
        end
        ST_JUMP: begin
          pc      <= {pc[WIDTH-1:28], ir[25:0], 2'b00};
          st      <= ST_FETCH;
          mem_req <= 1'b1;
        end
        ST_ALUWB, ST_MEMWB, ST_ADDIWB: begin
          st      <= ST_FETCH;
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
        end
        default: begin
          st      <= ST_HALT;
          halted  <= 1'b1;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mc_core_hs.sv
// Bench for mc_core_hs: a 32-bit core with a wait-state memory model and a 64-bit/8-register core.
// Stores are observed on the memory port and matched against an expected queue.
module tb_mc_core_hs;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // 32-bit core, RESET_PC = 0x100
  logic        rst32 = 1'b0;
  logic        req32, we32, halt32;
  logic        rdy32 = 1'b0;
  logic [31:0] addr32, wdata32, rdata32, pc32;
  logic [3:0]  st32;
  logic [31:0] mem32 [0:255];

  mc_core_hs #(.WIDTH(32), .NREG(32), .RESET_PC(32'h100)) dut32 (
    .clk(clk), .reset(rst32), .mem_req(req32), .mem_we(we32), .mem_addr(addr32),
    .mem_wdata(wdata32), .mem_rdata(rdata32), .mem_ready(rdy32), .pc(pc32),
    .state(st32), .halted(halt32)
  );
  assign rdata32 = mem32[addr32[9:2]];

  // 64-bit core, 8 registers, RESET_PC = 0
  logic        rst64 = 1'b0;
  logic        req64, we64, halt64;
  logic        rdy64 = 1'b0;
  logic [63:0] addr64, wdata64, rdata64, pc64;
  logic [3:0]  st64;
  logic [63:0] mem64 [0:255];

  mc_core_hs #(.WIDTH(64), .NREG(8), .RESET_PC(64'h0)) dut64 (
    .clk(clk), .reset(rst64), .mem_req(req64), .mem_we(we64), .mem_addr(addr64),
    .mem_wdata(wdata64), .mem_rdata(rdata64), .mem_ready(rdy64), .pc(pc64),
    .state(st64), .halted(halt64)
  );
  assign rdata64 = mem64[addr64[9:2]];

  // Scoreboard and monitor state
  logic [63:0]  exp32 [$];
  logic [63:0]  wq32 [$];
  logic [127:0] exp64 [$];
  logic [127:0] wq64 [$];
  logic [31:0]  fq_addr [$];
  int           fq_cyc [$];
  logic [31:0]  rdq [$];
  int wait_f = 0;
  int wait_d = 0;
  int cnt32 = 0;
  int req_halt32 = 0;
  logic [31:0] lp32;
  logic [63:0] lp64;

  // Memory responders: decide mem_ready on the falling edge for the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!req32) begin
      cnt32 = 0;
      rdy32 = 1'b0;
    end else if (cnt32 >= ((addr32 < 32'h100) ? wait_d : wait_f)) begin
      rdy32 = 1'b1;
      cnt32 = 0;
      if (we32) begin
        mem32[addr32[9:2]] = wdata32;
        wq32.push_back({addr32, wdata32});
      end
      if (st32 == 4'd1) begin
        fq_addr.push_back(addr32);
        fq_cyc.push_back(cyc);
      end
    end else begin
      rdy32 = 1'b0;
      cnt32++;
    end
    if (req32 && !we32 && (addr32 < 32'h100)) rdq.push_back(addr32);
    if (req32 && halt32) req_halt32++;

    if (req64) begin
      rdy64 = 1'b1;
      if (we64) begin
        mem64[addr64[9:2]] = wdata64;
        wq64.push_back({addr64, wdata64});
      end
    end else begin
      rdy64 = 1'b0;
    end
  end

  function automatic logic [31:0] i_ty(input logic [5:0] op, input int rs, input int rt, input int imm);
    i_ty = {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] r_ty(input int rs, input int rt, input int rd, input logic [5:0] fn);
    r_ty = {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn};
  endfunction

  function automatic logic [31:0] j_ty(input int tgt);
    j_ty = {6'h02, tgt[27:2]};
  endfunction

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  function automatic int fcyc(input logic [31:0] a);
    fcyc = -1;
    for (int i = fq_addr.size() - 1; i >= 0; i--)
      if (fq_addr[i] == a) fcyc = fq_cyc[i];
  endfunction

  function automatic logic [31:0] fnext(input logic [31:0] a);
    fnext = 32'hFFFF_FFFF;
    for (int i = fq_addr.size() - 2; i >= 0; i--)
      if (fq_addr[i] == a) fnext = fq_addr[i+1];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic put32(input logic [31:0] w);
    mem32[lp32[9:2]] = w;
    lp32 = lp32 + 32'd4;
  endtask

  task automatic put64(input logic [31:0] w);
    mem64[lp64[9:2]] = {32'h0, w};
    lp64 = lp64 + 64'd4;
  endtask

  task automatic begin32();
    rst32 = 1'b0;
    for (int i = 0; i < 256; i++) mem32[i] = HALT_I;
    exp32.delete();
    wq32.delete();
    fq_addr.delete();
    fq_cyc.delete();
    rdq.delete();
    wait_f = 0;
    wait_d = 0;
    lp32 = 32'h100;
    tick(2);
  endtask

  task automatic wait_halt32(input int budget);
    int n = 0;
    while (!halt32 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    begin32();
    total++;
    if (pc32 !== 32'h100) begin bad++; $display("FAIL reset_pc: got %h want 00000100", pc32); end
    total++;
    if (st32 !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", st32); end
    total++;
    if (req32 !== 1'b0 || halt32 !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: req=%b halted=%b want 0 0", req32, halt32);
    end
    rst32 = 1'b1;
    tick();
    total++;
    if (req32 !== 1'b1 || we32 !== 1'b0 || addr32 !== 32'h100) begin
      bad++; $display("FAIL first_fetch: req=%b we=%b addr=%h want 1 0 00000100", req32, we32, addr32);
    end
    wait_halt32(50);
    total++;
    if (halt32 !== 1'b1) begin bad++; $display("FAIL reset_halt: halted=%b want 1", halt32); end
  endtask

  task automatic test_zero_wait();
    logic [63:0] e, o;
    begin32();
    put32(i_ty(6'h08, 0, 1, 5));
    put32(i_ty(6'h08, 0, 2, -3));
    put32(r_ty(1, 2, 3, 6'h20));
    put32(r_ty(2, 1, 4, 6'h2A));
    put32(r_ty(1, 2, 5, 6'h2A));
    put32(r_ty(1, 2, 6, 6'h22));
    put32(r_ty(1, 2, 7, 6'h24));
    put32(r_ty(1, 2, 8, 6'h25));
    put32(i_ty(6'h08, 0, 0, 7));
    put32(i_ty(6'h2B, 0, 3, 'h40)); exp32.push_back({32'h40, 32'd2});
    put32(i_ty(6'h2B, 0, 4, 'h44)); exp32.push_back({32'h44, 32'd1});
    put32(i_ty(6'h2B, 0, 5, 'h48)); exp32.push_back({32'h48, 32'd0});
    put32(i_ty(6'h2B, 0, 6, 'h4C)); exp32.push_back({32'h4C, 32'd8});
    put32(i_ty(6'h2B, 0, 7, 'h50)); exp32.push_back({32'h50, 32'd5});
    put32(i_ty(6'h2B, 0, 8, 'h54)); exp32.push_back({32'h54, 32'hFFFF_FFFD});
    put32(i_ty(6'h2B, 0, 0, 'h58)); exp32.push_back({32'h58, 32'd0});
    put32(HALT_I);
    rst32 = 1'b1;
    wait_halt32(400);
    total++;
    if (halt32 !== 1'b1) begin bad++; $display("FAIL zw_halt: halted=%b want 1", halt32); end
    total++;
    if (fcyc(32'h104) - fcyc(32'h100) !== 4) begin
      bad++; $display("FAIL zw_addi_latency: got %0d want 4", fcyc(32'h104) - fcyc(32'h100));
    end
    total++;
    if (fcyc(32'h110) - fcyc(32'h100) !== 16) begin
      bad++; $display("FAIL zw_four_instr_cycles: got %0d want 16", fcyc(32'h110) - fcyc(32'h100));
    end
    total++;
    if (wq32.size() !== exp32.size()) begin
      bad++; $display("FAIL zw_store_count: got %0d want %0d", wq32.size(), exp32.size());
    end
    while (exp32.size() > 0) begin
      e = exp32.pop_front();
      o = (wq32.size() > 0) ? wq32.pop_front() : 64'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL zw_store: got addr/data %h want %h", o, e); end
    end
  endtask

  task automatic test_wait_states();
    logic [63:0] e, o;
    begin32();
    wait_d = 3;
    mem32[2] = 32'hDEAD_BEEF;
    put32(i_ty(6'h23, 0, 5, 8));
    put32(i_ty(6'h2B, 0, 5, 'h60)); exp32.push_back({32'h60, 32'hDEAD_BEEF});
    put32(HALT_I);
    rst32 = 1'b1;
    wait_halt32(200);
    total++;
    if (halt32 !== 1'b1) begin bad++; $display("FAIL ws_halt: halted=%b want 1", halt32); end
    total++;
    if (fcyc(32'h104) - fcyc(32'h100) !== 8) begin
      bad++; $display("FAIL ws_lw_latency: got %0d want 8", fcyc(32'h104) - fcyc(32'h100));
    end
    total++;
    if (rdq.size() !== 4) begin bad++; $display("FAIL ws_read_cycles: got %0d want 4", rdq.size()); end
    foreach (rdq[i]) begin
      total++;
      if (rdq[i] !== 32'h8) begin bad++; $display("FAIL ws_addr_stable: got %h want 00000008", rdq[i]); end
    end
    total++;
    if (wq32.size() !== exp32.size()) begin
      bad++; $display("FAIL ws_store_count: got %0d want %0d", wq32.size(), exp32.size());
    end
    while (exp32.size() > 0) begin
      e = exp32.pop_front();
      o = (wq32.size() > 0) ? wq32.pop_front() : 64'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL ws_store: got addr/data %h want %h", o, e); end
    end
  endtask

  task automatic test_branches();
    logic [63:0] e, o;
    begin32();
    put32(i_ty(6'h08, 0, 1, 7));
    put32(i_ty(6'h08, 0, 2, 7));
    put32(i_ty(6'h04, 1, 2, 2));
    put32(i_ty(6'h08, 0, 10, 1));
    put32(i_ty(6'h08, 0, 10, 1));
    put32(i_ty(6'h05, 1, 2, 2));
    put32(j_ty('h140));
    lp32 = 32'h140;
    put32(i_ty(6'h2B, 0, 10, 'h64)); exp32.push_back({32'h64, 32'd0});
    put32(i_ty(6'h2B, 0, 1, 'h68));  exp32.push_back({32'h68, 32'd7});
    put32(HALT_I);
    rst32 = 1'b1;
    wait_halt32(200);
    total++;
    if (halt32 !== 1'b1) begin bad++; $display("FAIL br_halt: halted=%b want 1", halt32); end
    total++;
    if (fnext(32'h108) !== 32'h114) begin bad++; $display("FAIL beq_taken: next fetch %h want 00000114", fnext(32'h108)); end
    total++;
    if (fnext(32'h114) !== 32'h118) begin bad++; $display("FAIL bne_fallthrough: next fetch %h want 00000118", fnext(32'h114)); end
    total++;
    if (fnext(32'h118) !== 32'h140) begin bad++; $display("FAIL jump_target: next fetch %h want 00000140", fnext(32'h118)); end
    total++;
    if (fcyc(32'h114) - fcyc(32'h108) !== 3) begin
      bad++; $display("FAIL beq_latency: got %0d want 3", fcyc(32'h114) - fcyc(32'h108));
    end
    total++;
    if (fcyc(32'h140) - fcyc(32'h118) !== 3) begin
      bad++; $display("FAIL j_latency: got %0d want 3", fcyc(32'h140) - fcyc(32'h118));
    end
    while (exp32.size() > 0) begin
      e = exp32.pop_front();
      o = (wq32.size() > 0) ? wq32.pop_front() : 64'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL br_store: got addr/data %h want %h", o, e); end
    end
  endtask

  task automatic test_sw_halt();
    logic [63:0] e, o;
    begin32();
    put32(i_ty(6'h08, 0, 3, 'h1234));
    put32(i_ty(6'h2B, 0, 3, 4)); exp32.push_back({32'h4, 32'h1234});
    put32(32'hFC00_0000);
    rst32 = 1'b1;
    wait_halt32(100);
    total++;
    if (halt32 !== 1'b1 || st32 !== 4'd12) begin
      bad++; $display("FAIL sh_halt: halted=%b state=%0d want 1 12", halt32, st32);
    end
    total++;
    if (wq32.size() !== 1) begin bad++; $display("FAIL sh_write_count: got %0d want 1", wq32.size()); end
    while (exp32.size() > 0) begin
      e = exp32.pop_front();
      o = (wq32.size() > 0) ? wq32.pop_front() : 64'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL sh_store: got addr/data %h want %h", o, e); end
    end
    req_halt32 = 0;
    tick(20);
    total++;
    if (req_halt32 !== 0 || req32 !== 1'b0) begin
      bad++; $display("FAIL sh_req_quiet: req cycles=%0d want 0", req_halt32);
    end
    total++;
    if (pc32 !== 32'h10C || halt32 !== 1'b1) begin
      bad++; $display("FAIL sh_pc_frozen: pc=%h halted=%b want 0000010c 1", pc32, halt32);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    begin32();
    wait_d = 10;
    put32(i_ty(6'h08, 0, 3, 'h77));
    put32(i_ty(6'h2B, 0, 3, 'h20));
    put32(HALT_I);
    rst32 = 1'b1;
    n = 0;
    while (st32 !== 4'd6 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (st32 !== 4'd6 || req32 !== 1'b1) begin
      bad++; $display("FAIL rm_reach_memwr: state=%0d req=%b want 6 1", st32, req32);
    end
    tick(2);
    rst32 = 1'b0;
    #1;
    total++;
    if (req32 !== 1'b0 || st32 !== 4'd0) begin
      bad++; $display("FAIL rm_async_drop: req=%b state=%0d want 0 0", req32, st32);
    end
    lp32 = 32'h100;
    put32(HALT_I);
    wait_d = 0;
    tick();
    fq_addr.delete();
    fq_cyc.delete();
    rst32 = 1'b1;
    wait_halt32(50);
    total++;
    if (fq_addr.size() < 1 || fq_addr[0] !== 32'h100) begin
      bad++; $display("FAIL rm_refetch: fetches=%0d want first at 00000100", fq_addr.size());
    end
    total++;
    if (wq32.size() !== 0) begin bad++; $display("FAIL rm_no_write: got %0d writes want 0", wq32.size()); end
  endtask

  task automatic test_wide();
    logic [127:0] e, o;
    int n;
    rst64 = 1'b0;
    for (int i = 0; i < 256; i++) mem64[i] = {32'h0, HALT_I};
    exp64.delete();
    wq64.delete();
    lp64 = 64'h0;
    tick(2);
    total++;
    if (pc64 !== 64'h0 || st64 !== 4'd0 || req64 !== 1'b0) begin
      bad++; $display("FAIL w_reset: pc=%h state=%0d req=%b want 0 0 0", pc64, st64, req64);
    end
    put64(i_ty(6'h08, 0, 2, 1));
    put64(r_ty(0, 2, 3, 6'h22));
    put64(r_ty(3, 0, 4, 6'h2A));
    put64(i_ty(6'h08, 0, 9, 'h55));
    put64(i_ty(6'h2B, 0, 3, 'h80));  exp64.push_back({64'h80, 64'hFFFF_FFFF_FFFF_FFFF});
    put64(i_ty(6'h2B, 0, 1, 'h88));  exp64.push_back({64'h88, 64'h55});
    put64(i_ty(6'h2B, 0, 9, 'h90));  exp64.push_back({64'h90, 64'h55});
    put64(i_ty(6'h2B, 0, 4, 'h98));  exp64.push_back({64'h98, 64'h1});
    put64(i_ty(6'h2B, 0, 10, 'hA0)); exp64.push_back({64'hA0, 64'h1});
    put64(HALT_I);
    rst64 = 1'b1;
    n = 0;
    while (!halt64 && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (halt64 !== 1'b1) begin bad++; $display("FAIL w_halt: halted=%b want 1", halt64); end
    total++;
    if (wq64.size() !== exp64.size()) begin
      bad++; $display("FAIL w_store_count: got %0d want %0d", wq64.size(), exp64.size());
    end
    while (exp64.size() > 0) begin
      e = exp64.pop_front();
      o = (wq64.size() > 0) ? wq64.pop_front() : 128'hx;
      total++;
      if (o !== e) begin bad++; $display("FAIL w_store: got addr/data %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branches();
    test_sw_halt();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
